// File: rtl/alu_mdu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_mdu_pkg                                                                |
// | Function codes and multiply/divide FSM state encoding for alu_mdu.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_mdu_pkg;

  localparam int unsigned c_func_add   = 0;
  localparam int unsigned c_func_sub   = 1;
  localparam int unsigned c_func_and   = 2;
  localparam int unsigned c_func_or    = 3;
  localparam int unsigned c_func_slt   = 4;
  localparam int unsigned c_func_xor   = 5;
  localparam int unsigned c_func_sltu  = 6;
  localparam int unsigned c_func_nor   = 7;
  localparam int unsigned c_func_sll   = 8;
  localparam int unsigned c_func_srl   = 9;
  localparam int unsigned c_func_sra   = 10;
  localparam int unsigned c_func_mult  = 11;
  localparam int unsigned c_func_multu = 12;
  localparam int unsigned c_func_div   = 13;
  localparam int unsigned c_func_divu  = 14;
  localparam int unsigned c_func_mfhi  = 15;
  localparam int unsigned c_func_mflo  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// +----------------------------------------------------------------------------+
// | mdu_iter                                                                   |
// | Iterative shift-add multiplier / restoring divider with final sign fix.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;

  mdu_state_t           r_state;
  mdu_state_t           w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div;
  logic                 r_bzero;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_trial;
  logic                 w_div_ok;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_a_neg = op_signed & a[WIDTH-1];
  assign w_b_neg = op_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // acc = {partial product, multiplier} or {remainder, dividend/quotient}
  assign w_addend    = r_acc[0] ? r_opnd : '0;
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_ok    = ~w_div_trial[WIDTH];
  assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0]
                                : {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = op_div ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (r_cnt == c_cnt_w'(1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div   <= 1'b0;
      r_bzero <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
      r_opnd  <= w_b_mag;
      r_cnt   <= c_cnt_w'(WIDTH);
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_div   <= op_div;
      r_bzero <= (b == '0);
    end else if (r_state == ST_MUL) begin
      r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      r_cnt <= r_cnt - c_cnt_w'(1);
    end else if (r_state == ST_DIV) begin
      r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  // Divide-by-zero forces LO to all ones; the remainder already equals a.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign hi   = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign lo   = r_div ? (r_bzero ? '1 : w_quo) : w_prod[WIDTH-1:0];
  assign done = (r_state == ST_FIX);
  assign busy = (r_state != ST_IDLE);
  assign dz   = r_div & r_bzero;

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// +----------------------------------------------------------------------------+
// | alu_mdu                                                                    |
// | Registered EX-stage ALU with iterative MIPS-style multiply/divide and HI/LO.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  res,
  output logic              is_zero,
  output logic              div_by_zero,
  output logic              illegal_op,
  output logic              busy,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int c_shw = $clog2(WIDTH);

  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_out_valid;
  logic             r_illegal;
  logic             r_dbz;

  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_mdu_hi;
  logic [WIDTH-1:0] w_mdu_lo;
  logic [c_shw-1:0] w_shamt;
  logic             w_illegal;
  logic             w_is_mdu;
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_accept;
  logic             w_start;
  logic             w_mdu_busy;
  logic             w_mdu_done;
  logic             w_mdu_dz;

  assign w_shamt  = b[c_shw-1:0];
  assign in_ready = ~w_mdu_busy;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_start  = w_accept & w_is_mdu;

  always_comb begin
    w_alu       = '0;
    w_illegal   = 1'b0;
    w_is_mdu    = 1'b0;
    w_is_div    = 1'b0;
    w_is_signed = 1'b0;
    case (func)
      FUNC_W'(c_func_add):  w_alu = a + b;
      FUNC_W'(c_func_sub):  w_alu = a - b;
      FUNC_W'(c_func_and):  w_alu = a & b;
      FUNC_W'(c_func_or):   w_alu = a | b;
      FUNC_W'(c_func_xor):  w_alu = a ^ b;
      FUNC_W'(c_func_nor):  w_alu = ~(a | b);
      FUNC_W'(c_func_slt):  w_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      FUNC_W'(c_func_sltu): w_alu = {{(WIDTH-1){1'b0}}, a < b};
      FUNC_W'(c_func_sll):  w_alu = a << w_shamt;
      FUNC_W'(c_func_srl):  w_alu = a >> w_shamt;
      FUNC_W'(c_func_sra):  w_alu = $unsigned($signed(a) >>> w_shamt);
      FUNC_W'(c_func_mfhi): w_alu = r_hi;
      FUNC_W'(c_func_mflo): w_alu = r_lo;
      FUNC_W'(c_func_mult): begin
        w_is_mdu    = 1'b1;
        w_is_signed = 1'b1;
      end
      FUNC_W'(c_func_multu): w_is_mdu = 1'b1;
      FUNC_W'(c_func_div): begin
        w_is_mdu    = 1'b1;
        w_is_div    = 1'b1;
        w_is_signed = 1'b1;
      end
      FUNC_W'(c_func_divu): begin
        w_is_mdu = 1'b1;
        w_is_div = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .op_div    (w_is_div),
    .op_signed (w_is_signed),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (w_mdu_busy),
    .done      (w_mdu_done),
    .dz        (w_mdu_dz),
    .hi        (w_mdu_hi),
    .lo        (w_mdu_lo)
  );

  // Accept and MDU completion never coincide: in_ready is low during FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      if (w_accept && !w_is_mdu) begin
        r_res       <= w_alu;
        r_illegal   <= w_illegal;
        r_out_valid <= 1'b1;
      end
      if (w_mdu_done && !flush) begin
        r_hi        <= w_mdu_hi;
        r_lo        <= w_mdu_lo;
        r_res       <= w_mdu_lo;
        r_out_valid <= 1'b1;
        if (w_mdu_dz) r_dbz <= 1'b1;
      end
      if (w_start && w_is_div) r_dbz <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign res         = r_res;
  assign is_zero     = r_out_valid & (r_res == '0);
  assign illegal_op  = r_illegal;
  assign div_by_zero = r_dbz;
  assign busy        = w_mdu_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// +----------------------------------------------------------------------------+
// | tb_alu_mdu                                                                 |
// | Scoreboard bench for alu_mdu with directed, hand-computed vectors.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_mdu;

  localparam int W  = 32;
  localparam int FW = 5;

  localparam logic [FW-1:0] F_ADD = 5'd0,  F_SUB  = 5'd1,  F_AND  = 5'd2,  F_OR   = 5'd3;
  localparam logic [FW-1:0] F_SLT = 5'd4,  F_XOR  = 5'd5,  F_SLTU = 5'd6,  F_NOR  = 5'd7;
  localparam logic [FW-1:0] F_SLL = 5'd8,  F_SRL  = 5'd9,  F_SRA  = 5'd10, F_MULT = 5'd11;
  localparam logic [FW-1:0] F_MULTU = 5'd12, F_DIV = 5'd13, F_DIVU = 5'd14;
  localparam logic [FW-1:0] F_MFHI = 5'd15, F_MFLO = 5'd16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [FW-1:0] func = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, is_zero, div_by_zero, illegal_op, busy;
  logic [W-1:0]  res, hi, lo;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .FUNC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .res(res), .is_zero(is_zero), .div_by_zero(div_by_zero),
    .illegal_op(illegal_op), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic         chk_hl;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         chk_dbz;
    logic         dbz;
    logic         ill;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got res %h, expected no output", res);
      end else begin
        m_e = q.pop_front();
        chk({m_e.nm, ".res"}, res, m_e.res);
        chk({m_e.nm, ".is_zero"}, W'(is_zero), W'(m_e.res == '0));
        chk({m_e.nm, ".illegal_op"}, W'(illegal_op), W'(m_e.ill));
        if (m_e.chk_hl) begin
          chk({m_e.nm, ".hi"}, hi, m_e.hi);
          chk({m_e.nm, ".lo"}, lo, m_e.lo);
        end
        if (m_e.chk_dbz) chk({m_e.nm, ".div_by_zero"}, W'(div_by_zero), W'(m_e.dbz));
      end
    end
  end

  task automatic push(input string nm, input logic [W-1:0] r, input logic hl,
                      input logic [W-1:0] h, input logic [W-1:0] l,
                      input logic cd, input logic d, input logic il);
    exp_t e;
    e.nm = nm; e.res = r; e.chk_hl = hl; e.hi = h; e.lo = l;
    e.chk_dbz = cd; e.dbz = d; e.ill = il;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready 0, expected 1 within 200 cycles");
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input logic [FW-1:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_ready();
    in_valid = 1'b1; func = f; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sc(input string nm, input logic [FW-1:0] f, input logic [W-1:0] av,
                    input logic [W-1:0] bv, input logic [W-1:0] r);
    push(nm, r, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(f, av, bv);
  endtask

  task automatic md(input string nm, input logic [FW-1:0] f, input logic [W-1:0] av,
                    input logic [W-1:0] bv, input logic [W-1:0] h, input logic [W-1:0] l,
                    input logic d);
    push(nm, l, 1'b1, h, l, 1'b1, d, 1'b0);
    issue(f, av, bv);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".res"}, res, '0);
    chk({tag, ".hi"}, hi, '0);
    chk({tag, ".lo"}, lo, '0);
    chk({tag, ".out_valid"}, W'(out_valid), '0);
    chk({tag, ".busy"}, W'(busy), '0);
    chk({tag, ".in_ready"}, W'(in_ready), W'(1));
    chk({tag, ".div_by_zero"}, W'(div_by_zero), '0);
    chk({tag, ".illegal_op"}, W'(illegal_op), '0);
  endtask

  initial begin
    int n;
    #12;
    chk_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, issued back to back
    sc("add_wrap",   F_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000);
    sc("sub_zero",   F_SUB,  32'h5,        32'h5,        32'h0);
    sc("sub_wrap",   F_SUB,  32'h0,        32'h1,        32'hFFFFFFFF);
    sc("and",        F_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
    sc("or",         F_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
    sc("xor",        F_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
    sc("nor",        F_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F);
    sc("slt_neg",    F_SLT,  32'hFFFFFFFF, 32'h1,        32'h1);
    sc("sltu_big",   F_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0);
    sc("sltu_small", F_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1);
    sc("sll31",      F_SLL,  32'h1,        32'd31,       32'h80000000);
    sc("sll_mask",   F_SLL,  32'h3,        32'h21,       32'h6);
    sc("srl",        F_SRL,  32'h80000000, 32'h4,        32'h08000000);
    sc("sra_neg",    F_SRA,  32'h80000000, 32'h4,        32'hF8000000);
    sc("sra_pos",    F_SRA,  32'h40000000, 32'h4,        32'h04000000);

    // MULT latency and HI/LO readback
    md("mult", F_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mult_busy_cycles", W'(n), W'(33));
    sc("mfhi", F_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF);
    sc("mflo", F_MFLO, 32'h0, 32'h0, 32'hFFFFFFFA);
    md("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // Divides
    md("div_neg_a",  F_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    md("div_neg_b",  F_DIV,  32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0);
    md("divu_zero",  F_DIVU, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 1'b1);
    push("add_dbz_sticky", 32'h3, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    issue(F_ADD, 32'h1, 32'h2);
    md("div_min_m1", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
    md("divu",       F_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);

    // Flush mid-divide with a request held the whole time
    issue(F_DIV, 32'd1000, 32'd7);
    in_valid = 1'b1; func = F_ADD; a = 32'h1; b = 32'h1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush.busy_before", W'(busy), W'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.busy", W'(busy), '0);
    chk("flush.in_ready", W'(in_ready), W'(1));
    chk("flush.out_valid", W'(out_valid), '0);
    chk("flush.hi", hi, 32'd2);
    chk("flush.lo", lo, 32'd14);
    @(posedge clk); #1;
    chk("flush.out_valid_later", W'(out_valid), '0);

    // Undefined functions
    push("illegal31", '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    issue(5'd31, 32'h1234, 32'h5678);
    push("illegal17", '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    issue(5'd17, 32'h1, 32'h1);

    // Async reset in the middle of a MULT
    md("divu_zero2", F_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1);
    sc("add_pre_rst", F_ADD, 32'h11, 32'h22, 32'h33);
    issue(F_MULT, 32'h3, 32'h4);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async_reset");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    sc("add_post_rst", F_ADD, 32'h2, 32'h3, 32'h5);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, registered successor to the single-cycle CPU ALU.
- Keeps all existing integer ops (ADD, SUB, AND, OR, SLT, XOR, SLTU) and adds NOR, shifts, and an iterative MIPS-style multiply/divide unit with HI/LO registers.
- Sits in the EX stage. The pipeline stalls on in_ready low and consumes results on out_valid.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, 8 or more.
- FUNC_W, 5, width of the func opcode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an op; equals !busy
- func  in  FUNC_W  opcode from the shared defines
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm); shift amount is b[$clog2(WIDTH)-1:0]
- flush  in  1  abort the in-flight op and drop any request this cycle
- out_valid  out  1  one-cycle pulse: res is valid
- res  out  WIDTH  registered result
- is_zero  out  1  (res == 0), qualified by out_valid
- div_by_zero  out  1  sticky until the next accepted DIV/DIVU
- illegal_op  out  1  pulses with out_valid for an undefined func
- busy  out  1  multi-cycle op in progress
- hi, lo  out  WIDTH  architectural HI/LO, for debug and observation

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; res, hi, lo = 0; out_valid, busy, div_by_zero, illegal_op = 0; in_ready = 1.
- An op is accepted when in_valid && in_ready && !flush.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO):
  - res is registered at the accept edge; out_valid is high for the following cycle. Latency is 1.
  - ADD and SUB wrap modulo 2^WIDTH with no overflow trap.
  - SLT compares signed; SLTU compares unsigned; the result is zero-extended 0 or 1.
  - SRA sign-fills.
- Undefined func: res = 0, illegal_op = 1, out_valid = 1, latency 1.
- MULT, MULTU, DIV, DIVU use an FSM with states IDLE, MUL, DIV, FIX.
  - Accept edge: latch operands and take magnitudes for signed ops. Go to MUL or DIV; busy = 1; counter = WIDTH.
  - MUL: shift-add, one bit per cycle. DIV: restoring divide, one quotient bit per cycle. Decrement the counter; at 0 go to FIX.
  - FIX (one cycle): apply sign correction and write HI/LO. Set res = new LO, out_valid = 1, busy = 0, and return to IDLE.
  - Total latency from accept edge to out_valid cycle is WIDTH+1 edges. in_ready is low throughout.
- MULT/MULTU: {HI, LO} = full 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed ops truncate toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = a, div_by_zero = 1. The full latency still applies.
  - Signed MIN / -1: LO = MIN, HI = 0, div_by_zero = 0.
- MFHI/MFLO issued while busy: not accepted because in_ready is low. After FIX they read the new values.
- flush:
  - In any state it returns the FSM to IDLE the next edge. busy = 0; HI/LO and div_by_zero are unchanged; no out_valid.
  - It also suppresses out_valid for a single-cycle result registered on the same edge.
  - flush together with in_valid means nothing is accepted.
- in_valid held while busy is ignored. The request is not queued; the pipeline must hold it.
- Back-to-back single-cycle ops give one result per cycle.
- A new op may be accepted in the same cycle that FIX pulses out_valid: in_ready is 1 in the cycle after FIX.

Decomposition:
- Extend the shared alu_defines.vh with FUNC_W-wide codes:
  - ADD 0, SUB 1, AND 2, OR 3, SLT 4, XOR 5, SLTU 6, NOR 7
  - SLL 8, SRL 9, SRA 10
  - MULT 11, MULTU 12, DIV 13, DIVU 14
  - MFHI 15, MFLO 16
- Add the FSM state encodings to the same file.
- One sub-module, mdu_iter, holds the MUL/DIV datapath (accumulator, counter, sign fix). alu_mdu holds the combinational ops, handshake and HI/LO.

Test Plan:
1. Reset, then ADD with a=0x7FFFFFFF, b=1 → next cycle out_valid=1, res=0x80000000, is_zero=0. SUB with a=5, b=5 → res=0, is_zero=1.
2. SLT with a=0xFFFFFFFF, b=1 → res=1. SLTU with the same operands → res=0. SRA with a=0x80000000, b=4 → res=0xF8000000.
3. MULT with a=0xFFFFFFFE (-2), b=3 → in_ready low for 33 cycles, then out_valid with res=LO=0xFFFFFFFA and HI=0xFFFFFFFF. A following MFHI → 0xFFFFFFFF.
4. DIV with a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with a=7, b=0 → LO=0xFFFFFFFF, HI=7, div_by_zero=1.
5. Issue DIV, then assert flush at iteration 10 → busy=0 next cycle, no out_valid, HI/LO hold their previous values, in_ready=1.
6. func=31 → illegal_op=1, res=0. Drop rst_n mid-MULT → all outputs return to reset values immediately, without waiting for a clock edge.
